lm32_tlb_csr: RTL and testbench

//  CSR front end and command sequencer for lm32_dtlb. Decodes TLB CSR writes into one-cycle update/invalidate/flush strobes, holds

---
 rtl/lm32_tlb_csr_pkg.sv | 25 ++
 rtl/lm32_tlb_csr_if.sv | 28 ++
 rtl/lm32_tlb_csr.sv | 146 ++++++++++++++
 tb/tb_lm32_tlb_csr.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lm32_tlb_csr_pkg.sv
// Shared constants for the DTLB CSR front end: CSR indices, TLBVADDR command codes, sequencer states.
package lm32_tlb_csr_pkg;

  localparam logic [4:0] LM32_CSR_TLBVADDR    = 5'h10;
  localparam logic [4:0] LM32_CSR_TLBPADDR    = 5'h11;
  localparam logic [4:0] LM32_CSR_TLBBADVADDR = 5'h12;
  localparam logic [4:0] LM32_CSR_TLBMISSCNT  = 5'h13;

  // Low three bits of a TLBVADDR write; any other code is a plain load.
  localparam logic [2:0] LM32_TLBC_CMD_LOAD       = 3'b000;
  localparam logic [2:0] LM32_TLBC_CMD_INVALIDATE = 3'b001;
  localparam logic [2:0] LM32_TLBC_CMD_FLUSH      = 3'b010;

  typedef enum logic [1:0] {
    LM32_TLBC_STATE_IDLE  = 2'd0,
    LM32_TLBC_STATE_ISSUE = 2'd1,
    LM32_TLBC_STATE_ARM   = 2'd2,
    LM32_TLBC_STATE_SWEEP = 2'd3
  } tlbc_state_t;

  function automatic logic [31:0] page_align(input logic [31:0] addr, input int unsigned offset_width);
    return addr & ~((32'd1 << offset_width) - 32'd1);
  endfunction

endpackage

// File: rtl/lm32_tlb_csr_if.sv
// CSR bus, X-stage miss inputs and DTLB command outputs of the TLB CSR front end.
interface lm32_tlb_csr_if;
  logic [4:0]  csr_i;
  logic        csr_write_enable;
  logic [31:0] csr_write_data;
  logic [31:0] csr_read_data;
  logic        stall_x;
  logic [31:0] address_x;
  logic        dtlb_miss;
  logic        dtlb_stall_req;
  logic [31:0] tlbvaddr;
  logic [31:0] tlbpaddr;
  logic        update;
  logic        invalidate;
  logic        flush;
  logic        busy;
  logic        miss_exception;

  modport master (
    output csr_i, csr_write_enable, csr_write_data, stall_x, address_x, dtlb_miss, dtlb_stall_req,
    input  csr_read_data, tlbvaddr, tlbpaddr, update, invalidate, flush, busy, miss_exception
  );

  modport slave (
    input  csr_i, csr_write_enable, csr_write_data, stall_x, address_x, dtlb_miss, dtlb_stall_req,
    output csr_read_data, tlbvaddr, tlbpaddr, update, invalidate, flush, busy, miss_exception
  );
endinterface

// File: rtl/lm32_tlb_csr.sv
// TLB CSR decode, DTLB command sequencer and miss capture for lm32_dtlb.
// Optional miss counter enabled by defining LM32_TLB_MISS_CNT_EN.
//
// state | meaning
// IDLE  | accepting CSR writes
// ISSUE | one strobe (update/invalidate/flush) asserted to the DTLB
// ARM   | flush issued, DTLB raising its stall request
// SWEEP | waiting for the DTLB flush sweep to finish
module lm32_tlb_csr
  import lm32_tlb_csr_pkg::*;
#(
  parameter int page_size = 4096,
  parameter int cnt_width = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  lm32_tlb_csr_if.slave  bus
);

  localparam int unsigned offset_width = $clog2(page_size);

  tlbc_state_t state;
  logic [31:0] tlbvaddr_q, tlbpaddr_q, badvaddr, cnt_read, read_data;
  logic        update_q, invalidate_q, flush_q, busy_q, miss_exc_q;
  logic        idle_write, wr_vaddr, wr_paddr, miss_q;
  logic [2:0]  cmd;

  assign idle_write = bus.csr_write_enable && (state == LM32_TLBC_STATE_IDLE);
  assign wr_vaddr   = idle_write && (bus.csr_i == LM32_CSR_TLBVADDR);
  assign wr_paddr   = idle_write && (bus.csr_i == LM32_CSR_TLBPADDR);
  assign cmd        = bus.csr_write_data[2:0];
  assign miss_q     = bus.dtlb_miss && !bus.stall_x;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= LM32_TLBC_STATE_IDLE;
      tlbvaddr_q   <= '0;
      tlbpaddr_q   <= '0;
      update_q     <= 1'b0;
      invalidate_q <= 1'b0;
      flush_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      update_q     <= 1'b0;
      invalidate_q <= 1'b0;
      flush_q      <= 1'b0;
      case (state)
        LM32_TLBC_STATE_IDLE: begin
          if (wr_vaddr) begin
            tlbvaddr_q <= page_align(bus.csr_write_data, offset_width);
            if (cmd == LM32_TLBC_CMD_INVALIDATE) begin
              invalidate_q <= 1'b1;
              busy_q       <= 1'b1;
              state        <= LM32_TLBC_STATE_ISSUE;
            end else if (cmd == LM32_TLBC_CMD_FLUSH) begin
              flush_q <= 1'b1;
              busy_q  <= 1'b1;
              state   <= LM32_TLBC_STATE_ISSUE;
            end
          end
          if (wr_paddr) begin
            tlbpaddr_q <= page_align(bus.csr_write_data, offset_width);
            update_q   <= 1'b1;
            busy_q     <= 1'b1;
            state      <= LM32_TLBC_STATE_ISSUE;
          end
        end
        // flush_q still holds the strobe issued this cycle
        LM32_TLBC_STATE_ISSUE: begin
          if (flush_q) begin
            state <= LM32_TLBC_STATE_ARM;
          end else begin
            busy_q <= 1'b0;
            state  <= LM32_TLBC_STATE_IDLE;
          end
        end
        LM32_TLBC_STATE_ARM: state <= LM32_TLBC_STATE_SWEEP;
        LM32_TLBC_STATE_SWEEP: begin
          if (!bus.dtlb_stall_req) begin
            busy_q <= 1'b0;
            state  <= LM32_TLBC_STATE_IDLE;
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= LM32_TLBC_STATE_IDLE;
        end
      endcase
    end
  end

  // Misses are captured regardless of sequencer state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      badvaddr   <= '0;
      miss_exc_q <= 1'b0;
    end else begin
      miss_exc_q <= miss_q;
      if (miss_q) badvaddr <= bus.address_x;
    end
  end

`ifdef LM32_TLB_MISS_CNT_EN
  logic [cnt_width-1:0] miss_cnt;
  logic                 wr_cnt;

  assign wr_cnt = idle_write && (bus.csr_i == LM32_CSR_TLBMISSCNT);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      miss_cnt <= '0;
    end else if (wr_cnt) begin
      miss_cnt <= miss_q ? cnt_width'(1) : '0;
    end else if (miss_q && (miss_cnt != '1)) begin
      miss_cnt <= miss_cnt + cnt_width'(1);
    end
  end

  assign cnt_read = 32'(miss_cnt);
`else
  logic [31:0] cnt_width_unused;
  assign cnt_width_unused = 32'(cnt_width);
  assign cnt_read         = '0;
`endif

  always_comb begin
    read_data = '0;
    case (bus.csr_i)
      LM32_CSR_TLBVADDR:    read_data = tlbvaddr_q;
      LM32_CSR_TLBPADDR:    read_data = tlbpaddr_q;
      LM32_CSR_TLBBADVADDR: read_data = badvaddr;
      LM32_CSR_TLBMISSCNT:  read_data = cnt_read;
      default:              read_data = '0;
    endcase
  end

  assign bus.csr_read_data  = read_data;
  assign bus.tlbvaddr       = tlbvaddr_q;
  assign bus.tlbpaddr       = tlbpaddr_q;
  assign bus.update         = update_q;
  assign bus.invalidate     = invalidate_q;
  assign bus.flush          = flush_q;
  assign bus.busy           = busy_q;
  assign bus.miss_exception = miss_exc_q;

endmodule

// File: tb/tb_lm32_tlb_csr.sv
// Self-checking bench for lm32_tlb_csr; DTLB strobes are checked against a scoreboard of expected commands.
module tb_lm32_tlb_csr;
  import lm32_tlb_csr_pkg::*;

`ifdef LM32_TLB_MISS_CNT_EN
  localparam int CNT_W = 2;
`else
  localparam int CNT_W = 16;
`endif

  typedef struct {
    int          cyc;
    logic        upd;
    logic        inv;
    logic        fl;
    logic [31:0] v;
    logic [31:0] p;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  exp_t sb[$];

  lm32_tlb_csr_if bus ();

  lm32_tlb_csr #(.page_size(4096), .cnt_width(CNT_W)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every strobe must match the oldest expected command, in the expected cycle.
  always @(negedge clk) begin
    if (rst_n && (bus.update || bus.invalidate || bus.flush)) begin
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL strobe_unexpected cyc=%0d upd=%0b inv=%0b fl=%0b", cyc, bus.update, bus.invalidate, bus.flush);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (cyc !== e.cyc || {bus.update, bus.invalidate, bus.flush} !== {e.upd, e.inv, e.fl} ||
            bus.tlbvaddr !== e.v || bus.tlbpaddr !== e.p) begin
          fails++;
          $display("FAIL strobe cyc=%0d/%0d uif=%b/%b v=%h/%h p=%h/%h (got/exp)", cyc, e.cyc,
                   {bus.update, bus.invalidate, bus.flush}, {e.upd, e.inv, e.fl}, bus.tlbvaddr, e.v, bus.tlbpaddr, e.p);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic csr_write(input logic [4:0] a, input logic [31:0] d);
    bus.csr_i = a; bus.csr_write_data = d; bus.csr_write_enable = 1'b1;
    step();
    bus.csr_write_enable = 1'b0;
  endtask

  task automatic csr_read(input logic [4:0] a, output logic [31:0] d);
    bus.csr_i = a; #1;
    d = bus.csr_read_data;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.update, bus.invalidate, bus.flush, bus.busy, bus.miss_exception} !== 5'b0 ||
        bus.tlbvaddr !== 32'h0 || bus.tlbpaddr !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs uifbm=%b v=%h p=%h exp all zero", {bus.update, bus.invalidate, bus.flush, bus.busy, bus.miss_exception}, bus.tlbvaddr, bus.tlbpaddr);
    end
    csr_read(LM32_CSR_TLBBADVADDR, rd);
    checks++;
    if (rd !== 32'h0) begin fails++; $display("FAIL reset_badvaddr got=%h exp=0", rd); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_update();
    logic [31:0] rd;
    csr_write(LM32_CSR_TLBVADDR, 32'h0000_5000);
    checks++;
    if (bus.tlbvaddr !== 32'h0000_5000 || bus.busy !== 1'b0) begin
      fails++; $display("FAIL load_vaddr v=%h busy=%b exp 00005000 0", bus.tlbvaddr, bus.busy);
    end
    sb.push_back('{cyc + 1, 1'b1, 1'b0, 1'b0, 32'h0000_5000, 32'h8000_3000});
    csr_write(LM32_CSR_TLBPADDR, 32'h8000_3000);
    checks++;
    if (bus.busy !== 1'b1) begin fails++; $display("FAIL update_busy got=%b exp=1", bus.busy); end
    step();
    checks++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL update_busy_drop got=%b exp=0", bus.busy); end
    csr_read(LM32_CSR_TLBPADDR, rd);
    checks++;
    if (rd !== 32'h8000_3000) begin fails++; $display("FAIL read_paddr got=%h exp=80003000", rd); end
  endtask

  task automatic test_invalidate();
    sb.push_back('{cyc + 1, 1'b0, 1'b1, 1'b0, 32'h0000_7000, 32'h8000_3000});
    csr_write(LM32_CSR_TLBVADDR, 32'h0000_7001);
    checks++;
    if (bus.busy !== 1'b1) begin fails++; $display("FAIL inval_busy got=%b exp=1", bus.busy); end
    step();
    checks++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL inval_busy_drop got=%b exp=0", bus.busy); end
  endtask

  task automatic test_flush_and_drop();
    logic [31:0] rd;
    int busy_lo = 0;
    sb.push_back('{cyc + 1, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 32'h8000_3000});
    csr_write(LM32_CSR_TLBVADDR, 32'h0000_0002);
    bus.dtlb_stall_req = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      if (i == 100) begin
        bus.csr_i = LM32_CSR_TLBPADDR; bus.csr_write_data = 32'h1234_5000; bus.csr_write_enable = 1'b1;
      end
      step();
      bus.csr_write_enable = 1'b0;
      if (bus.busy !== 1'b1) busy_lo++;
    end
    checks++;
    if (busy_lo != 0) begin fails++; $display("FAIL flush_busy_held low_cycles=%0d exp=0", busy_lo); end
    bus.dtlb_stall_req = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin fails++; $display("FAIL flush_busy_at_fall got=%b exp=1", bus.busy); end
    step();
    checks++;
    if (bus.busy !== 1'b0) begin fails++; $display("FAIL flush_busy_after got=%b exp=0", bus.busy); end
    csr_read(LM32_CSR_TLBPADDR, rd);
    checks++;
    if (rd !== 32'h8000_3000) begin fails++; $display("FAIL dropped_write paddr got=%h exp=80003000", rd); end
    sb.push_back('{cyc + 1, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_9000});
    csr_write(LM32_CSR_TLBPADDR, 32'h0000_9ABC);
    step();
  endtask

  task automatic test_miss();
    logic [31:0] rd;
    bus.dtlb_miss = 1'b1; bus.stall_x = 1'b0; bus.address_x = 32'hDEAD_B00C;
    step();
    bus.dtlb_miss = 1'b0;
    csr_read(LM32_CSR_TLBBADVADDR, rd);
    checks++;
    if (bus.miss_exception !== 1'b1 || rd !== 32'hDEAD_B00C) begin
      fails++; $display("FAIL miss_capture exc=%b bad=%h exp 1 deadb00c", bus.miss_exception, rd);
    end
    step();
    checks++;
    if (bus.miss_exception !== 1'b0) begin fails++; $display("FAIL miss_one_cycle got=%b exp=0", bus.miss_exception); end
    bus.dtlb_miss = 1'b1; bus.stall_x = 1'b1; bus.address_x = 32'h1111_0000;
    step();
    bus.dtlb_miss = 1'b0; bus.stall_x = 1'b0;
    csr_read(LM32_CSR_TLBBADVADDR, rd);
    checks++;
    if (bus.miss_exception !== 1'b0 || rd !== 32'hDEAD_B00C) begin
      fails++; $display("FAIL miss_stalled exc=%b bad=%h exp 0 deadb00c", bus.miss_exception, rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    bus.dtlb_miss = 1'b1; bus.address_x = 32'hA000_0004;
    step();
    bus.address_x = 32'hB000_0008;
    checks++;
    if (bus.miss_exception !== 1'b1) begin fails++; $display("FAIL b2b_first got=%b exp=1", bus.miss_exception); end
    step();
    bus.dtlb_miss = 1'b0;
    csr_read(LM32_CSR_TLBBADVADDR, rd);
    checks++;
    if (bus.miss_exception !== 1'b1 || rd !== 32'hB000_0008) begin
      fails++; $display("FAIL b2b_second exc=%b bad=%h exp 1 b0000008", bus.miss_exception, rd);
    end
    // Miss arriving in the same cycle as a command write.
    bus.dtlb_miss = 1'b1; bus.address_x = 32'hC000_000C;
    sb.push_back('{cyc + 1, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0004_2000});
    csr_write(LM32_CSR_TLBPADDR, 32'h0004_2FFF);
    bus.dtlb_miss = 1'b0;
    csr_read(LM32_CSR_TLBBADVADDR, rd);
    checks++;
    if (bus.miss_exception !== 1'b1 || bus.busy !== 1'b1 || rd !== 32'hC000_000C) begin
      fails++; $display("FAIL miss_while_busy exc=%b busy=%b bad=%h exp 1 1 c000000c", bus.miss_exception, bus.busy, rd);
    end
    step();
  endtask

  task automatic test_unmapped();
    logic [31:0] rd;
    csr_read(5'h05, rd);
    checks++;
    if (rd !== 32'h0) begin fails++; $display("FAIL unmapped_read got=%h exp=0", rd); end
  endtask

  task automatic test_miss_cnt();
    logic [31:0] rd;
`ifdef LM32_TLB_MISS_CNT_EN
    csr_write(LM32_CSR_TLBMISSCNT, 32'h0);
    csr_read(LM32_CSR_TLBMISSCNT, rd);
    checks++;
    if (rd !== 32'h0) begin fails++; $display("FAIL cnt_clear got=%h exp=0", rd); end
    bus.dtlb_miss = 1'b1;
    repeat (3) step();
    bus.dtlb_miss = 1'b0;
    csr_read(LM32_CSR_TLBMISSCNT, rd);
    checks++;
    if (rd !== 32'd3) begin fails++; $display("FAIL cnt_three got=%0d exp=3", rd); end
    bus.dtlb_miss = 1'b1;
    csr_write(LM32_CSR_TLBMISSCNT, 32'h0);
    bus.dtlb_miss = 1'b0;
    csr_read(LM32_CSR_TLBMISSCNT, rd);
    checks++;
    if (rd !== 32'd1) begin fails++; $display("FAIL cnt_clear_and_miss got=%0d exp=1", rd); end
    bus.dtlb_miss = 1'b1;
    repeat (5) step();
    bus.dtlb_miss = 1'b0;
    csr_read(LM32_CSR_TLBMISSCNT, rd);
    checks++;
    if (rd !== 32'd3) begin fails++; $display("FAIL cnt_saturate got=%0d exp=3", rd); end
`else
    bus.dtlb_miss = 1'b1;
    repeat (3) step();
    bus.dtlb_miss = 1'b0;
    csr_write(LM32_CSR_TLBMISSCNT, 32'hFFFF_FFFF);
    csr_read(LM32_CSR_TLBMISSCNT, rd);
    checks++;
    if (rd !== 32'h0) begin fails++; $display("FAIL cnt_absent got=%h exp=0", rd); end
`endif
  endtask

  task automatic test_reset_mid_flush();
    sb.push_back('{cyc + 1, 1'b0, 1'b0, 1'b1, 32'h0000_3000, 32'h0004_2000});
    csr_write(LM32_CSR_TLBVADDR, 32'h0000_3002);
    bus.dtlb_stall_req = 1'b1;
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.tlbvaddr !== 32'h0) begin
      fails++; $display("FAIL reset_mid_flush busy=%b v=%h exp 0 0", bus.busy, bus.tlbvaddr);
    end
    #1 rst_n = 1'b1;
    bus.dtlb_stall_req = 1'b0;
    step();
    sb.push_back('{cyc + 1, 1'b1, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_6000});
    csr_write(LM32_CSR_TLBPADDR, 32'h0000_6000);
    step();
  endtask

  initial begin
    bus.csr_i = 5'h0; bus.csr_write_enable = 1'b0; bus.csr_write_data = 32'h0;
    bus.stall_x = 1'b0; bus.address_x = 32'h0; bus.dtlb_miss = 1'b0; bus.dtlb_stall_req = 1'b0;
    test_reset();
    test_update();
    test_invalidate();
    test_flush_and_drop();
    test_miss();
    test_back_to_back();
    test_unmapped();
    test_miss_cnt();
    test_reset_mid_flush();
    repeat (2) step();
    checks++;
    if (sb.size() != 0) begin fails++; $display("FAIL strobe_missing pending=%0d exp=0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", checks, fails);
    $finish;
  end

endmodule
